// File: rtl/byte_serializer.sv
// Parallel-to-serial stage: one-byte holding register plus shifter driving one bit per clk with shift_enable.
// Optional BYTE_SERIALIZER_PARITY_EN adds parity_out_o; latency accept->first bit = 1 cycle, backpressure via in_ready_o.
module byte_serializer #(
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       serial_out_o,
    output logic       shift_enable_o,
    output logic       byte_done_o,
    output logic       busy_o
`ifdef BYTE_SERIALIZER_PARITY_EN
    ,
    output logic       parity_out_o
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t     state_q;
    logic [7:0] hold_q;
    logic       hold_vld_q;
    logic [7:0] shifter_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] gap_cnt_q;
    logic       serial_q;
    logic       shift_en_q;
    logic       byte_done_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic       parity_q;
`endif

    logic last_bit;
    logic gap_end;
    logic load;

    function automatic logic first_bit(input logic [7:0] b);
        return MSB_FIRST ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] b);
        return MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == 3'd7);
    assign gap_end  = (state_q == GAP) && (gap_cnt_q == 4'd0);
    // A held byte enters the shifter from idle, straight after a byte (no gap), or when the gap expires.
    assign load     = hold_vld_q && ((state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)) || gap_end);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            shifter_q   <= 8'h00;
            bit_cnt_q   <= 3'd0;
            gap_cnt_q   <= 4'd0;
            serial_q    <= 1'b0;
            shift_en_q  <= 1'b0;
            byte_done_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            // Accept and load are mutually exclusive: accept needs an empty hold, load a full one.
            if (in_valid_i && !hold_vld_q) begin
                hold_q     <= in_data_i;
                hold_vld_q <= 1'b1;
            end else if (load) begin
                hold_vld_q <= 1'b0;
            end

            byte_done_q <= 1'b0;
            if (load) begin
                state_q    <= SHIFT;
                bit_cnt_q  <= 3'd0;
                serial_q   <= first_bit(hold_q);
                shifter_q  <= advance(hold_q);
                shift_en_q <= 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
                parity_q   <= ^hold_q;
`endif
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (last_bit) begin
                            state_q    <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_cnt_q  <= 4'(GAP_CYCLES - 1);
                            serial_q   <= 1'b0;
                            shift_en_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
                            parity_q   <= 1'b0;
`endif
                        end else begin
                            serial_q    <= first_bit(shifter_q);
                            shifter_q   <= advance(shifter_q);
                            bit_cnt_q   <= bit_cnt_q + 3'd1;
                            byte_done_q <= (bit_cnt_q == 3'd6);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready_o     = !hold_vld_q;
    assign serial_out_o   = serial_q;
    assign shift_enable_o = shift_en_q;
    assign byte_done_o    = byte_done_q;
    assign busy_o         = (state_q != IDLE) || hold_vld_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
    assign parity_out_o   = parity_q;
`endif

endmodule
